// File: rtl/ddr_package.sv
// Shared types for the DDR4 memory-model CAS responder: command encoding,
// responder FSM states and the countdown-queue entry.
package ddr_package;

  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;

  // Entry field widths; the responder's column width must equal RESP_COL_W.
  localparam int RESP_COL_W = 10;
  localparam int RESP_CNT_W = 8;

  typedef enum logic [1:0] {
    R_IDLE,
    R_PREAMBLE,
    R_RD_BURST,
    R_WR_BURST
  } resp_fsm_type;

  typedef struct packed {
    logic [1:0]            rw;
    logic [RESP_COL_W-1:0] col;
    logic [RESP_CNT_W-1:0] cnt;
  } resp_cmd_t;

endpackage

// File: rtl/resp_cmd_queue.sv
// FIFO of pending CAS commands; every entry's cnt counts down each cycle and
// saturates at zero, so the head reports when its data slot has arrived.
module resp_cmd_queue
  import ddr_package::*;
#(
  parameter int QDEPTH = 8,
  parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  resp_cmd_t        push_data,
  input  logic             pop,
  output resp_cmd_t        head,
  output logic             head_due,
  output logic [CNT_W-1:0] q_count,
  output logic             full
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  resp_cmd_t        entries_q [QDEPTH];
  resp_cmd_t        entries_d [QDEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == CNT_W'(QDEPTH));
  assign head     = entries_q[rd_ptr_q];
  assign head_due = (count_q != '0) && (head.cnt == '0);
  assign q_count  = count_q;
  assign pop_ok   = pop && (count_q != '0);
  // A full queue still accepts when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop_ok);

  always_comb begin
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (entries_q[i].cnt != '0) begin
        entries_d[i].cnt = entries_q[i].cnt - 1'b1;
      end
    end
    if (push_ok) begin
      entries_d[wr_ptr_q] = push_data;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        entries_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/ddr_cas_data_responder.sv
// Memory-side CAS responder: queues READ/WRITE commands, then after CL/CWL
// drives or captures a BURST_LEN burst against an internal word array.
module ddr_cas_data_responder
  import ddr_package::*;
#(
  parameter int CL        = 11,
  parameter int CWL       = 9,
  parameter int BURST_LEN = 8,
  parameter int DQ_W      = 64,
  parameter int ADDR_W    = RESP_COL_W,
  parameter int QDEPTH    = 8
) (
  input  logic                         clock_t,
  input  logic                         reset,
  input  logic                         cmd_valid,
  input  logic [1:0]                   cmd_rw,
  input  logic [ADDR_W-1:0]            cmd_col,
  input  logic [DQ_W-1:0]              dq_in,
  input  logic                         err_clr,
  output logic [DQ_W-1:0]              dq_out,
  output logic                         dq_oe,
  output logic                         dqs_oe,
  output logic                         wr_capture,
  output logic                         busy,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count,
  output logic                         timing_err,
  output logic                         overflow_err,
  output resp_fsm_type                 state_dbg
);

  localparam int BW  = $clog2(BURST_LEN);
  localparam int QCW = $clog2(QDEPTH + 1);

  logic [DQ_W-1:0] mem [2**ADDR_W];

  resp_fsm_type    state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic            due_prev_q, due_prev_d;
  logic            timing_err_q, timing_err_d;
  logic            overflow_err_q, overflow_err_d;
  logic [DQ_W-1:0] dq_out_q, dq_out_d;
  logic            dq_oe_q, dq_oe_d;
  logic            dqs_oe_q, dqs_oe_d;
  logic            wr_capture_q, wr_capture_d;

  logic            cmd_ok, pop, timing_set, last_beat, head_rd;
  resp_cmd_t       push_data, q_head;
  logic            q_head_due, q_full;
  logic [QCW-1:0]  q_cnt;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  // Beats walk sequentially and wrap inside the BURST_LEN-aligned block.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] col,
                                                  input logic [BW-1:0] k);
    logic [BW-1:0] low;
    low = col[BW-1:0] + k;
    return {col[ADDR_W-1:BW], low};
  endfunction

  // cmd_valid has no ready: a command is taken on every edge it is high with a
  // legal cmd_rw; a push into a full queue is dropped and raises overflow_err.
  assign cmd_ok        = cmd_valid && ((cmd_rw == READ) || (cmd_rw == WRITE));
  assign push_data.rw  = cmd_rw;
  assign push_data.col = RESP_COL_W'(cmd_col);
  assign push_data.cnt = (cmd_rw == READ) ? RESP_CNT_W'(CL - 2) : RESP_CNT_W'(CWL - 1);

  resp_cmd_queue #(.QDEPTH(QDEPTH), .CNT_W(QCW)) u_queue (
    .clk       (clock_t),
    .rst       (reset),
    .push      (cmd_ok),
    .push_data (push_data),
    .pop       (pop),
    .head      (q_head),
    .head_due  (q_head_due),
    .q_count   (q_cnt),
    .full      (q_full)
  );

  assign last_beat = (beat_q == BW'(BURST_LEN - 1));
  assign head_rd   = (q_head.rw == READ);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    col_d      = col_q;
    pop        = 1'b0;
    timing_set = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (q_head_due) begin
          pop     = 1'b1;
          col_d   = ADDR_W'(q_head.col);
          beat_d  = '0;
          state_d = head_rd ? R_PREAMBLE : R_WR_BURST;
        end
      end
      R_PREAMBLE: begin
        beat_d  = '0;
        state_d = R_RD_BURST;
      end
      default: begin
        beat_d = beat_q + 1'b1;
        if (last_beat) begin
          beat_d = '0;
          if (q_head_due) begin
            pop   = 1'b1;
            col_d = ADDR_W'(q_head.col);
            if (head_rd) begin
              state_d = (state_q == R_RD_BURST) ? R_RD_BURST : R_PREAMBLE;
            end else begin
              state_d = R_WR_BURST;
            end
            if (((state_q == R_RD_BURST) != head_rd) && due_prev_q) begin
              timing_set = 1'b1;
            end
          end else begin
            state_d = R_IDLE;
          end
        end
      end
    endcase

    // A read behind a read skips its preamble, so it may wait one cycle longer.
    if (q_head_due && !pop &&
        (!head_rd || (state_q != R_RD_BURST) || due_prev_q)) begin
      timing_set = 1'b1;
    end
    due_prev_d = q_head_due && !pop;

    timing_err_d   = (timing_err_q && !err_clr) || timing_set;
    overflow_err_d = (overflow_err_q && !err_clr) || (cmd_ok && q_full && !pop);

    dqs_oe_d     = (state_d == R_PREAMBLE) || (state_d == R_RD_BURST);
    dq_oe_d      = (state_d == R_RD_BURST);
    wr_capture_d = (state_d == R_WR_BURST);
    rd_addr      = beat_addr(col_d, beat_d);
    dq_out_d     = dq_oe_d ? mem[rd_addr] : '0;
  end

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      state_q        <= R_IDLE;
      beat_q         <= '0;
      col_q          <= '0;
      due_prev_q     <= 1'b0;
      timing_err_q   <= 1'b0;
      overflow_err_q <= 1'b0;
      dq_out_q       <= '0;
      dq_oe_q        <= 1'b0;
      dqs_oe_q       <= 1'b0;
      wr_capture_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      col_q          <= col_d;
      due_prev_q     <= due_prev_d;
      timing_err_q   <= timing_err_d;
      overflow_err_q <= overflow_err_d;
      dq_out_q       <= dq_out_d;
      dq_oe_q        <= dq_oe_d;
      dqs_oe_q       <= dqs_oe_d;
      wr_capture_q   <= wr_capture_d;
    end
  end

  // The array is never reset; reset forces R_IDLE so no beat is written.
  assign wr_addr = beat_addr(col_q, beat_q);
  always_ff @(posedge clock_t) begin
    if (state_q == R_WR_BURST) begin
      mem[wr_addr] <= dq_in;
    end
  end

  assign dq_out       = dq_out_q;
  assign dq_oe        = dq_oe_q;
  assign dqs_oe       = dqs_oe_q;
  assign wr_capture   = wr_capture_q;
  assign timing_err   = timing_err_q;
  assign overflow_err = overflow_err_q;
  assign q_count      = q_cnt;
  assign busy         = (q_cnt != '0) || (state_q != R_IDLE);
  assign state_dbg    = state_q;

endmodule

// File: doc/ddr_cas_data_responder.md
Name: ddr_cas_data_responder

Overview:
- Memory-side counterpart of the controller's CAS-to-data burst tracker.
- Accepts READ/WRITE CAS commands and holds each one in a countdown queue. After CL (read) or CWL (write) cycles it drives or captures a burst of BURST_LEN beats against an internal word array.
- Flags any command spacing that violates burst, preamble or turnaround timing.
- Sits in the DDR4 memory model, on the far side of the command/DQ interface.

Parameters:
- CL, 11: read latency in clock_t cycles; must be ≥2.
- CWL, 9: write latency in clock_t cycles; must be ≥1.
- BURST_LEN, 8: beats per burst, one beat per cycle; power of 2.
- DQ_W, 64: data width.
- ADDR_W, 10: column/word address width; array depth is 2**ADDR_W.
- QDEPTH, 8: maximum outstanding commands.

Ports:
- clock_t  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  CAS command strobe, sampled on posedge.
- cmd_rw  in  2  READ/WRITE encoding from the shared package; other codes are ignored.
- cmd_col  in  ADDR_W  burst start column.
- dq_in  in  DQ_W  write data from the controller.
- err_clr  in  1  clears the sticky error flags.
- dq_out  out  DQ_W  read data.
- dq_oe  out  1  high while a read beat is driven.
- dqs_oe  out  1  high during the read preamble and read beats.
- wr_capture  out  1  high in cycles whose dq_in is sampled.
- busy  out  1  queue non-empty or FSM not idle.
- q_count  out  $clog2(QDEPTH+1)  number of queued entries.
- timing_err  out  1  sticky timing violation flag.
- overflow_err  out  1  sticky queue overflow flag.

Behaviour:
- **Reset:** all outputs are 0 immediately (asynchronous). Queue cleared, FSM goes to R_IDLE, counters zeroed. Array contents are not reset and are retained across reset. cmd_valid is ignored while reset is high. Reset mid-burst aborts the burst, with no partial write of the current beat.
- **Timing reference:** T is the posedge that samples the command. L = CL for READ, L = CWL for WRITE. Beat k occupies the cycle starting at edge T+L+k.
  - Read: dq_out/dq_oe are valid in beat k's cycle; the preamble cycle (dqs_oe=1, dq_oe=0) starts at edge T+CL-1.
  - Write: dq_in is captured at the end of beat k's cycle, and wr_capture=1 during that cycle.
- **Queue:** FIFO; each entry holds {rw, col, cnt}.
  - Push loads cnt = L-1 (READ: CL-2, so it matches the preamble lead).
  - All cnt fields decrement every cycle and saturate at 0.
  - Push and pop in the same cycle are legal.
  - Push when full (q_count == QDEPTH and no pop) drops the command and sets overflow_err.
  - An invalid cmd_rw code is dropped silently.
- **FSM states:** R_IDLE, R_PREAMBLE, R_RD_BURST, R_WR_BURST.
  - From R_IDLE: a head READ with cnt==0 pops and goes to R_PREAMBLE; a head WRITE with cnt==0 pops and goes to R_WR_BURST.
  - R_PREAMBLE always goes to R_RD_BURST after 1 cycle.
  - In a burst, the beat counter runs 0..BURST_LEN-1. On the last beat:
    - Head READ due (cnt==0) while in R_RD_BURST: go directly to R_RD_BURST with no preamble; dqs_oe stays high (seamless).
    - Head WRITE due while in R_WR_BURST: go directly to R_WR_BURST (seamless).
    - Head READ due while in R_WR_BURST: go to R_PREAMBLE.
    - Head WRITE due while in R_RD_BURST: go to R_WR_BURST.
    - Otherwise: go to R_IDLE.
  - In the two cross-direction last-beat transitions, set timing_err if the head became due before the current burst ended.
- **Deferral:** a head entry whose cnt is 0 while the FSM cannot launch it (burst in progress, not the last beat) stays queued. timing_err is set on the first cycle the entry is overdue. The entry launches at the first legal slot, and its data follows that slot.
- **Addressing:** beat k address = {col[ADDR_W-1:B], (col[B-1:0]+k) mod BURST_LEN}, where B = log2(BURST_LEN). This is sequential with wrap inside the aligned block.
- **Read pipeline:** array read is registered and launched in the preamble or previous beat so dq_out is valid on time. dq_out = 0 when dq_oe = 0.
- **Error flags:**
  - Sticky until err_clr.
  - err_clr together with a new error in the same cycle leaves the flag set.
- **busy** = (q_count != 0) or (state != R_IDLE).

Decomposition:
- Shared package (ddr_package.pkg):
  - rw encoding constants READ/WRITE (2-bit).
  - resp_fsm_type enum {R_IDLE, R_PREAMBLE, R_RD_BURST, R_WR_BURST}.
  - Queue entry struct resp_cmd_t {rw, col, cnt}.
- One sub-module: resp_cmd_queue, the QDEPTH FIFO with per-entry saturating countdown. It exposes head, head_due, q_count, full, push and pop.
- The FSM, address generation and array stay in the top module.

Test Plan:
1. WRITE col=0x10 at edge T, dq_in = 0xA0+k during the beats → wr_capture high for cycles T+9..T+16. Then READ col=0x10 at edge T+20 → dqs_oe high at T+30, dq_oe high T+31..T+38 with dq_out = 0xA0..0xA7, and no errors.
2. READ col=0x0D → beat order is columns 0x0D, 0x0E, 0x0F, 0x08..0x0C (wrap within the aligned 8-block).
3. READs at T and T+8 → dqs_oe continuous from T+10 to T+26, a single preamble, dq_oe high T+11..T+26, timing_err = 0.
4. READs at T and T+4 → second burst deferred to T+19..T+26; timing_err sets at T+15. err_clr then clears it.
5. Nine commands on consecutive edges with QDEPTH=8 → overflow_err=1, q_count peaks at 8, the ninth command is never executed.
6. Assert reset during READ beat 3 → dq_oe, dqs_oe, busy and q_count are 0 without waiting for a clock edge. A subsequent READ of previously written data returns the pre-reset contents.
